// File: rtl/floppy_pkg.sv
// Shared types and widths for the floppy track streamer and its prefetch FIFO.
package floppy_pkg;

  localparam int DSK_ADDR_W         = 22;
  localparam int TRACK_LEN_W        = 16;
  localparam int DEFAULT_BYTE_TICKS = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fetch_state_t;

  function automatic logic [DSK_ADDR_W-1:0] track_addr(
    input logic [DSK_ADDR_W-1:0]  base,
    input logic [TRACK_LEN_W-1:0] off
  );
    return base + DSK_ADDR_W'(off);
  endfunction

endpackage

// File: rtl/floppy_prefetch_fifo.sv
// Prefetch FIFO of {index tag, data byte} entries, first-word fall-through.
// Caller may push when full only if it pops in the same clock.
module floppy_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == CAP);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)           wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/floppy_track_streamer.sv
// Drive-side GCR byte source: prefetches track bytes from image memory and
// presents one byte per cell, with index marker, head-advance pacing and underrun flag.
//
// state   | meaning
// IDLE    | waiting for run and FIFO room
// REQ     | dskReadReq held; drop set means the pending ack belongs to a flushed track
// FILL    | byte pushed; step offset (wrapping at trackLen)
module floppy_track_streamer
  import floppy_pkg::*;
#(
  parameter int BYTE_TICKS = DEFAULT_BYTE_TICKS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   _reset,
  input  logic                   cen,
  input  logic                   _enable,
  input  logic                   motorOn,
  input  logic [DSK_ADDR_W-1:0]  trackBase,
  input  logic [TRACK_LEN_W-1:0] trackLen,
  input  logic                   advanceDriveHead,
  output logic                   dskReadReq,
  output logic [DSK_ADDR_W-1:0]  dskReadAddr,
  input  logic                   dskReadAck,
  input  logic [7:0]             dskReadData,
  output logic [7:0]             readData,
  output logic                   newByteReady,
  output logic                   index,
  output logic                   underrun
);

  localparam int TW = $clog2(BYTE_TICKS);
  localparam logic [TW-1:0] TICK_MAX  = TW'(BYTE_TICKS - 1);
  localparam logic [TW-1:0] ADV_CLAMP = TW'(3);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_CAP = CW'(FIFO_DEPTH);

  fetch_state_t           state;
  logic                   drop;
  logic [TRACK_LEN_W-1:0] offset;
  logic [TRACK_LEN_W-1:0] offset_inc;
  logic [TRACK_LEN_W-1:0] offset_next;
  logic [DSK_ADDR_W-1:0]  req_addr;
  logic                   req_tag;

  logic [DSK_ADDR_W-1:0]  base_q;
  logic [TRACK_LEN_W-1:0] len_q;
  logic                   run_q;
  logic                   run;
  logic                   flush;

  logic [TW-1:0]          timer;
  logic                   expire;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [8:0]             fifo_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

  assign run   = !_enable && motorOn && (trackLen != '0);
  assign flush = (trackBase != base_q) || (trackLen != len_q) || (run_q && !run);

  assign offset_inc  = offset + 1'b1;
  assign offset_next = (offset_inc == trackLen) ? '0 : offset_inc;

  assign dskReadAddr = (state == ST_REQ) ? req_addr : track_addr(trackBase, offset);

  // An ack arriving together with a flush is stale as well.
  assign fifo_push = (state == ST_REQ) && dskReadAck && !drop && !flush
                     && (!fifo_full || fifo_pop);
  assign expire    = cen && run && !flush && (timer == '0);
  assign fifo_pop  = expire && !fifo_empty;

  floppy_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (_reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({req_tag, dskReadData}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      base_q <= '0;
      len_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      base_q <= trackBase;
      len_q  <= trackLen;
      run_q  <= run;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state      <= ST_IDLE;
      dskReadReq <= 1'b0;
      drop       <= 1'b0;
      offset     <= '0;
      req_addr   <= '0;
      req_tag    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            offset <= '0;
          end else if (run && (fifo_count < FIFO_CAP)) begin
            state      <= ST_REQ;
            dskReadReq <= 1'b1;
            req_addr   <= track_addr(trackBase, offset);
            req_tag    <= (offset == '0);
          end
        end
        ST_REQ: begin
          if (flush) begin
            offset <= '0;
            drop   <= 1'b1;
          end
          if (dskReadAck) begin
            dskReadReq <= 1'b0;
            drop       <= 1'b0;
            state      <= (flush || drop) ? ST_IDLE : ST_FILL;
          end
        end
        ST_FILL: begin
          state  <= ST_IDLE;
          offset <= flush ? '0 : offset_next;
        end
        default: begin
          state      <= ST_IDLE;
          dskReadReq <= 1'b0;
          drop       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      timer        <= TICK_MAX;
      readData     <= '0;
      newByteReady <= 1'b0;
      index        <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (flush) begin
        timer    <= TICK_MAX;
        underrun <= 1'b0;
      end else if (cen && run) begin
        if (timer == '0)                                 timer <= TICK_MAX;
        else if (advanceDriveHead && (timer > ADV_CLAMP)) timer <= ADV_CLAMP;
        else                                             timer <= timer - 1'b1;
      end

      // Strobes last exactly one cen period so the consumer sees them once.
      if (!run) begin
        newByteReady <= 1'b0;
        index        <= 1'b0;
      end else if (cen) begin
        newByteReady <= fifo_pop;
        index        <= fifo_pop && fifo_rd[8];
        if (expire) begin
          if (!fifo_empty) begin
            readData <= fifo_rd[7:0];
          end else begin
            readData <= '0;
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_floppy_track_streamer.sv
// Randomized bench for floppy_track_streamer: memory responder, byte-stream
// reference model (byte k = image[base + k mod len]) and per-scenario checks.
module tb_floppy_track_streamer;

  localparam int BT = 128;

  logic        clk = 1'b0;
  logic        _reset;
  logic        cen;
  logic        _enable;
  logic        motorOn;
  logic [21:0] trackBase;
  logic [15:0] trackLen;
  logic        advanceDriveHead;
  logic        dskReadReq;
  logic [21:0] dskReadAddr;
  logic        dskReadAck;
  logic [7:0]  dskReadData;
  logic [7:0]  readData;
  logic        newByteReady;
  logic        index;
  logic        underrun;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  int cen_pct = 100;
  int ack_delay = 3;

  typedef struct {
    logic [7:0] d;
    logic       ix;
    int         t;
  } ev_t;

  ev_t         ev_q[$];
  logic [21:0] req_log[$];

  floppy_track_streamer dut (
    .clk              (clk),
    ._reset           (_reset),
    .cen              (cen),
    ._enable          (_enable),
    .motorOn          (motorOn),
    .trackBase        (trackBase),
    .trackLen         (trackLen),
    .advanceDriveHead (advanceDriveHead),
    .dskReadReq       (dskReadReq),
    .dskReadAddr      (dskReadAddr),
    .dskReadAck       (dskReadAck),
    .dskReadData      (dskReadData),
    .readData         (readData),
    .newByteReady     (newByteReady),
    .index            (index),
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [7:0] exp_data(input logic [21:0] base, input int len, input int k);
    logic [21:0] a;
    a = base + 22'(k % len);
    return mem_byte(a);
  endfunction

  function automatic logic exp_ix(input int len, input int k);
    return (k % len) == 0;
  endfunction

  // cen driver
  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cen = ($urandom_range(1, 100) <= cen_pct);
    end
  end

  // cen ticks sampled by the DUT so far
  initial begin
    forever begin
      @(posedge clk);
      if (cen === 1'b1) ticks++;
    end
  end

  // image memory: one outstanding request, ack after ack_delay clocks
  initial begin
    bit          busy;
    int          wait_cnt;
    logic [21:0] addr;
    busy = 0;
    wait_cnt = 0;
    addr = '0;
    dskReadAck = 1'b0;
    dskReadData = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      dskReadAck = 1'b0;
      if (_reset !== 1'b1 || dskReadReq !== 1'b1) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          wait_cnt = ack_delay;
          addr = dskReadAddr;
          req_log.push_back(addr);
        end
        if (wait_cnt == 0) begin
          dskReadAck = 1'b1;
          dskReadData = mem_byte(addr);
          busy = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // strobe monitor
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (newByteReady === 1'b1 && prev !== 1'b1)
        ev_q.push_back('{readData, index, ticks});
      prev = newByteReady;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by 900000 ns, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic [21:0] base, input logic [15:0] len);
    _reset = 1'b0;
    trackBase = base;
    trackLen = len;
    _enable = 1'b0;
    motorOn = 1'b1;
    advanceDriveHead = 1'b0;
    repeat (3) @(negedge clk);
    _reset = 1'b1;
    @(negedge clk);
    ev_q.delete();
    req_log.delete();
  endtask

  task automatic wait_events(input int n, input int max_clk, output bit ok);
    int c;
    c = 0;
    while (ev_q.size() < n && c < max_clk) begin
      @(negedge clk);
      c++;
    end
    ok = (ev_q.size() >= n);
  endtask

  task automatic wait_req(input int max_clk, output bit ok);
    int c;
    c = 0;
    @(negedge clk);
    while (dskReadReq !== 1'b1 && c < max_clk) begin
      @(negedge clk);
      c++;
    end
    ok = (dskReadReq === 1'b1);
  endtask

  task automatic test_reset();
    _reset = 1'b0;
    trackBase = 22'h1234;
    trackLen = 16'd7;
    _enable = 1'b0;
    motorOn = 1'b1;
    advanceDriveHead = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (dskReadReq !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dskReadReq); end
    total++; if (dskReadAddr !== 22'h1234) begin bad++; $display("FAIL reset_addr: got %06h want 001234", dskReadAddr); end
    total++; if (readData !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", readData); end
    total++; if (newByteReady !== 1'b0) begin bad++; $display("FAIL reset_nbr: got %b want 0", newByteReady); end
    total++; if (index !== 1'b0) begin bad++; $display("FAIL reset_index: got %b want 0", index); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_steady();
    bit ok;
    do_reset(22'h1000, 16'd5);
    ack_delay = 3;
    cen_pct = 100;
    wait_events(12, 12 * BT + 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL steady_timeout: got %0d strobes want 12", ev_q.size()); end
    for (int k = 0; k < ev_q.size() && k < 12; k++) begin
      total++;
      if (ev_q[k].d !== exp_data(22'h1000, 5, k)) begin
        bad++; $display("FAIL steady_data[%0d]: got %02h want %02h", k, ev_q[k].d, exp_data(22'h1000, 5, k));
      end
      total++;
      if (ev_q[k].ix !== exp_ix(5, k)) begin
        bad++; $display("FAIL steady_index[%0d]: got %b want %b", k, ev_q[k].ix, exp_ix(5, k));
      end
      if (k > 0) begin
        total++;
        if (ev_q[k].t - ev_q[k-1].t != BT) begin
          bad++; $display("FAIL steady_interval[%0d]: got %0d want %0d", k, ev_q[k].t - ev_q[k-1].t, BT);
        end
      end
    end
    for (int k = 0; k < req_log.size() && k < 8; k++) begin
      total++;
      if (req_log[k] !== 22'h1000 + 22'(k % 5)) begin
        bad++; $display("FAIL steady_fetch_addr[%0d]: got %06h want %06h", k, req_log[k], 22'h1000 + 22'(k % 5));
      end
    end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL steady_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_advance();
    bit ok;
    int rise_t;
    int adv_t;
    int c;
    do_reset(22'h1000, 16'd5);
    ack_delay = 3;
    cen_pct = 100;
    wait_events(2, 2 * BT + 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL advance_start: got %0d strobes want 2", ev_q.size()); end
    if (ok) begin
      rise_t = ev_q[1].t;
      c = 0;
      while (ticks < rise_t + 10 && c < 100) begin @(negedge clk); c++; end
      advanceDriveHead = 1'b1;
      adv_t = ticks + 1;
      @(negedge clk);
      advanceDriveHead = 1'b0;
      wait_events(4, 2 * BT + 300, ok);
      total++; if (!ok) begin bad++; $display("FAIL advance_timeout: got %0d strobes want 4", ev_q.size()); end
      if (ok) begin
        total++;
        if (ev_q[2].t != adv_t + 4) begin
          bad++; $display("FAIL advance_early: got tick %0d want %0d", ev_q[2].t, adv_t + 4);
        end
        total++;
        if (ev_q[2].d !== exp_data(22'h1000, 5, 2)) begin
          bad++; $display("FAIL advance_data: got %02h want %02h", ev_q[2].d, exp_data(22'h1000, 5, 2));
        end
        total++;
        if (ev_q[3].t - ev_q[2].t != BT) begin
          bad++; $display("FAIL advance_after: got %0d want %0d", ev_q[3].t - ev_q[2].t, BT);
        end
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int c;
    int n0;
    bit quiet;
    do_reset(22'h1000, 16'd5);
    ack_delay = 3;
    cen_pct = 100;
    wait_events(2, 2 * BT + 300, ok);
    ack_delay = 2000;
    c = 0;
    while (underrun !== 1'b1 && c < 1500) begin @(negedge clk); c++; end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
    ack_delay = 3;
    n0 = ev_q.size();
    total++; if (readData !== 8'h00) begin bad++; $display("FAIL underrun_data: got %02h want 00", readData); end
    quiet = 1;
    repeat (300) begin
      @(negedge clk);
      if (newByteReady !== 1'b0) quiet = 0;
    end
    total++; if (!quiet || ev_q.size() != n0) begin bad++; $display("FAIL underrun_nostrobe: got %0d strobes want %0d", ev_q.size(), n0); end
    wait_events(n0 + 2, 2600, ok);
    total++; if (!ok) begin bad++; $display("FAIL underrun_resume: got %0d strobes want %0d", ev_q.size(), n0 + 2); end
    for (int k = 0; k < ev_q.size(); k++) begin
      total++;
      if (ev_q[k].d !== exp_data(22'h1000, 5, k) || ev_q[k].ix !== exp_ix(5, k)) begin
        bad++; $display("FAIL underrun_stream[%0d]: got %02h/%b want %02h/%b", k, ev_q[k].d, ev_q[k].ix,
                        exp_data(22'h1000, 5, k), exp_ix(5, k));
      end
    end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_track_change();
    bit ok;
    do_reset(22'h1000, 16'd5);
    ack_delay = 30;
    cen_pct = 100;
    wait_events(2, 2 * BT + 300, ok);
    wait_req(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL track_req: got %b want 1", dskReadReq); end
    @(posedge clk);
    #1;
    trackBase = 22'h2000;
    req_log.delete();
    repeat (3) @(negedge clk);
    ev_q.delete();
    wait_events(3, 3 * BT + 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL track_timeout: got %0d strobes want 3", ev_q.size()); end
    total++;
    if (req_log.size() == 0 || req_log[0] !== 22'h2000) begin
      bad++; $display("FAIL track_fetch_addr: got %06h want 002000", req_log.size() ? req_log[0] : 22'h3fffff);
    end
    for (int k = 0; k < ev_q.size(); k++) begin
      total++;
      if (ev_q[k].d !== exp_data(22'h2000, 5, k) || ev_q[k].ix !== exp_ix(5, k)) begin
        bad++; $display("FAIL track_stream[%0d]: got %02h/%b want %02h/%b", k, ev_q[k].d, ev_q[k].ix,
                        exp_data(22'h2000, 5, k), exp_ix(5, k));
      end
    end
    ack_delay = 3;
  endtask

  task automatic test_disable();
    bit ok;
    int n0;
    logic [7:0] last;
    bit quiet;
    int c;
    int t0;
    do_reset(22'h1000, 16'd5);
    ack_delay = 3;
    cen_pct = 100;
    wait_events(3, 3 * BT + 300, ok);
    @(posedge clk);
    #1;
    _enable = 1'b1;
    repeat (2) @(negedge clk);
    n0 = ev_q.size();
    last = (n0 > 0) ? ev_q[n0-1].d : 8'h00;
    quiet = 1;
    t0 = ticks;
    c = 0;
    while (ticks < t0 + 300 && c < 1000) begin
      @(negedge clk);
      c++;
      if (newByteReady !== 1'b0 || index !== 1'b0) quiet = 0;
    end
    total++; if (!quiet || ev_q.size() != n0) begin bad++; $display("FAIL disable_quiet: got %0d strobes want %0d", ev_q.size(), n0); end
    total++; if (readData !== last) begin bad++; $display("FAIL disable_hold: got %02h want %02h", readData, last); end
    _enable = 1'b0;
    ev_q.delete();
    wait_events(6, 6 * BT + 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL disable_restart: got %0d strobes want 6", ev_q.size()); end
    for (int k = 0; k < ev_q.size(); k++) begin
      total++;
      if (ev_q[k].d !== exp_data(22'h1000, 5, k) || ev_q[k].ix !== exp_ix(5, k)) begin
        bad++; $display("FAIL disable_stream[%0d]: got %02h/%b want %02h/%b", k, ev_q[k].d, ev_q[k].ix,
                        exp_data(22'h1000, 5, k), exp_ix(5, k));
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset(22'h1000, 16'd5);
    ack_delay = 30;
    cen_pct = 100;
    wait_events(2, 2 * BT + 300, ok);
    wait_req(400, ok);
    #2;
    _reset = 1'b0;
    #1;
    total++; if (dskReadReq !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0", dskReadReq); end
    total++; if (dskReadAddr !== 22'h1000) begin bad++; $display("FAIL areset_addr: got %06h want 001000", dskReadAddr); end
    total++; if (readData !== 8'h00 || newByteReady !== 1'b0 || index !== 1'b0 || underrun !== 1'b0) begin
      bad++; $display("FAIL areset_outputs: got %02h/%b/%b/%b want 00/0/0/0", readData, newByteReady, index, underrun);
    end
    repeat (2) @(negedge clk);
    req_log.delete();
    ev_q.delete();
    ack_delay = 3;
    _reset = 1'b1;
    wait_events(2, 2 * BT + 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_restart: got %0d strobes want 2", ev_q.size()); end
    total++;
    if (req_log.size() == 0 || req_log[0] !== 22'h1000) begin
      bad++; $display("FAIL areset_fetch_addr: got %06h want 001000", req_log.size() ? req_log[0] : 22'h3fffff);
    end
    for (int k = 0; k < ev_q.size(); k++) begin
      total++;
      if (ev_q[k].d !== exp_data(22'h1000, 5, k) || ev_q[k].ix !== exp_ix(5, k)) begin
        bad++; $display("FAIL areset_stream[%0d]: got %02h/%b want %02h/%b", k, ev_q[k].d, ev_q[k].ix,
                        exp_data(22'h1000, 5, k), exp_ix(5, k));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [21:0] base;
    int len;
    for (int it = 0; it < 3; it++) begin
      base = 22'($urandom);
      len = $urandom_range(1, 9);
      ack_delay = $urandom_range(0, 20);
      cen_pct = $urandom_range(40, 100);
      do_reset(base, 16'(len));
      wait_events(8, 8 * BT * 3 + 500, ok);
      total++; if (!ok) begin bad++; $display("FAIL random_timeout[%0d]: got %0d strobes want 8", it, ev_q.size()); end
      for (int k = 0; k < ev_q.size() && k < 8; k++) begin
        total++;
        if (ev_q[k].d !== exp_data(base, len, k) || ev_q[k].ix !== exp_ix(len, k)) begin
          bad++; $display("FAIL random_stream[%0d.%0d]: got %02h/%b want %02h/%b", it, k, ev_q[k].d, ev_q[k].ix,
                          exp_data(base, len, k), exp_ix(len, k));
        end
        if (k > 0) begin
          total++;
          if (ev_q[k].t - ev_q[k-1].t != BT) begin
            bad++; $display("FAIL random_interval[%0d.%0d]: got %0d want %0d", it, k, ev_q[k].t - ev_q[k-1].t, BT);
          end
        end
      end
    end
    cen_pct = 100;
    ack_delay = 3;
  endtask

  initial begin
    _reset = 1'b0;
    _enable = 1'b0;
    motorOn = 1'b1;
    trackBase = '0;
    trackLen = 16'd5;
    advanceDriveHead = 1'b0;
    test_reset();
    test_steady();
    test_advance();
    test_underrun();
    test_track_change();
    test_disable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
